// File: rtl/tx_iq_sched_pkg.sv
// Shared types and constants for the TX IQ source scheduler.
package tx_iq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GUARD = 2'd3
    } sched_state_e;

    localparam logic SRC_ACC  = 1'b0;
    localparam logic SRC_AXIS = 1'b1;

    // Winner of an arbitration round. A tie goes to axis under fixed
    // priority, otherwise to whichever source was not granted last.
    function automatic logic pick_winner(input logic acc_req,
                                         input logic axis_req,
                                         input logic prio_axis,
                                         input logic last_src);
        logic win;
        if (acc_req && axis_req) begin
            if (prio_axis) begin
                win = SRC_AXIS;
            end else begin
                win = ~last_src;
            end
        end else if (axis_req) begin
            win = SRC_AXIS;
        end else begin
            win = SRC_ACC;
        end
        return win;
    endfunction

endpackage

// File: rtl/strobe_counter.sv
// Clear/enable counter that sticks at all-ones instead of wrapping.
module strobe_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tx_iq_src_sched.sv
// Arbitrates the TX IQ path between the baseband accelerator and host
// playback, with a per-grant strobe limit, FIFO drain and guard gap.
module tx_iq_src_sched
    import tx_iq_sched_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int GUARD_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_acc,
    input  logic                   req_axis,
    input  logic                   done_acc,
    input  logic                   done_axis,
    input  logic                   iq_ready,
    input  logic                   fifo_empty,
    input  logic [CNT_WIDTH-1:0]   cfg_max_len,
    input  logic [GUARD_WIDTH-1:0] cfg_guard_len,
    input  logic                   cfg_prio_axis,
    output logic                   src_sel,
    output logic                   gnt_acc,
    output logic                   gnt_axis,
    output logic                   busy,
    output logic                   timeout,
    output logic [CNT_WIDTH-1:0]   sample_cnt
);

    sched_state_e           state_q, state_d;
    logic                   src_q, src_d;
    logic                   last_q, last_d;
    logic [CNT_WIDTH-1:0]   max_len_q, max_len_d;
    logic [GUARD_WIDTH-1:0] guard_len_q, guard_len_d;
    logic                   gnt_acc_q, gnt_axis_q, busy_q, timeout_q;
    logic                   timeout_d;

    logic                   win_s;
    logic                   done_sel_s;
    logic                   max_hit_s;
    logic                   guard_hit_s;
    logic                   samp_clr_s;
    logic [CNT_WIDTH-1:0]   sample_cnt_s;
    logic [GUARD_WIDTH-1:0] guard_cnt_s;

    assign win_s      = pick_winner(req_acc, req_axis, cfg_prio_axis, last_q);
    // Only the grantee's done pulse can end a grant.
    assign done_sel_s = (src_q == SRC_AXIS) ? done_axis : done_acc;
    // Look ahead by the strobe arriving this cycle so the limit ends on it.
    assign max_hit_s  = (max_len_q != '0) &&
                        (({1'b0, sample_cnt_s} + {{CNT_WIDTH{1'b0}}, iq_ready}) >=
                         {1'b0, max_len_q});
    assign guard_hit_s = ({1'b0, guard_cnt_s} + {{GUARD_WIDTH{1'b0}}, iq_ready}) >=
                         {1'b0, guard_len_q};

    strobe_counter #(.WIDTH(CNT_WIDTH)) u_sample_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (samp_clr_s),
        .en_i  ((state_q == ST_GRANT) && iq_ready),
        .cnt_o (sample_cnt_s)
    );

    strobe_counter #(.WIDTH(GUARD_WIDTH)) u_guard_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (state_q != ST_GUARD),
        .en_i  ((state_q == ST_GUARD) && iq_ready),
        .cnt_o (guard_cnt_s)
    );

    // Scheduler next state; config is latched only on grant start and guard entry.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        last_d      = last_q;
        max_len_d   = max_len_q;
        guard_len_d = guard_len_q;
        timeout_d   = 1'b0;
        samp_clr_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_acc || req_axis) begin
                    state_d    = ST_GRANT;
                    src_d      = win_s;
                    last_d     = win_s;
                    max_len_d  = cfg_max_len;
                    samp_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (done_sel_s) begin
                    state_d = ST_DRAIN;
                end else if (max_hit_s) begin
                    state_d   = ST_DRAIN;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_DRAIN: begin
                if ((src_q == SRC_AXIS) || fifo_empty) begin
                    if (cfg_guard_len == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_GUARD;
                        guard_len_d = cfg_guard_len;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_GUARD: begin
                if (guard_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GUARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched config and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_ACC;
            last_q      <= SRC_AXIS;
            max_len_q   <= '0;
            guard_len_q <= '0;
            gnt_acc_q   <= 1'b0;
            gnt_axis_q  <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            last_q      <= last_d;
            max_len_q   <= max_len_d;
            guard_len_q <= guard_len_d;
            gnt_acc_q   <= (state_d == ST_GRANT) && (src_d == SRC_ACC);
            gnt_axis_q  <= (state_d == ST_GRANT) && (src_d == SRC_AXIS);
            busy_q      <= (state_d != ST_IDLE);
            timeout_q   <= timeout_d;
        end
    end

    assign src_sel    = src_q;
    assign gnt_acc    = gnt_acc_q;
    assign gnt_axis   = gnt_axis_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign sample_cnt = sample_cnt_s;

endmodule
